bin_bcd4: RTL and testbench
===========================

Name: bin_bcd4

Overview:
- Registered 4-bit binary to 2-digit BCD converter.
- Takes a binary value 0..15 and produces a 5-bit packed BCD result: tens digit in bit 4, ones digit in bits 3:0.
- Used in display and readout paths where small counters feed decimal outputs.
- Synchronous to a single clock. Output is held in registers with a valid flag.

Parameters:
- LATENCY, 1, number of clock cycles from input capture to output update. Legal values are 1 and 2; any other value is a elaboration error.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies b. Sampled on the rising edge of clk.
- b  input  4  unsigned binary value, 0..15.
- p  output  5  packed BCD result. p[4] is the tens digit (0 or 1); p[3:0] is the ones digit (0..9).
- out_valid  output  1  high for one cycle when p carries a new result.

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low: rst_n low immediately forces p=5'b00000 and out_valid=0, and clears all internal pipeline registers. Reset is released synchronously to clk.
- Conversion function:
  - b<=9: tens=0, ones=b, so p={1'b0,b}.
  - b>=10: tens=1, ones=b-10, so p={1'b1,b-4'd10}.
  - p[3:0] is never 10..15.
- Full mapping (b -> p, binary):
  - 0..9 -> 0_0000..0_1001
  - 10 -> 1_0000
  - 11 -> 1_0001
  - 12 -> 1_0010
  - 13 -> 1_0011
  - 14 -> 1_0100
  - 15 -> 1_0101
- Pipeline timing:
  - LATENCY=1: an edge with in_valid=1 captures b; p updates on that same edge and out_valid=1 for the following cycle.
  - LATENCY=2: an additional register stage is inserted, so p and out_valid appear one edge later.
  - The converter is fully pipelined: it accepts a new input every cycle and has no backpressure.
- in_valid=0: p holds its last value and out_valid=0 for that slot.
- Back-to-back valid inputs produce back-to-back outputs in order, with no bubbles.
- Unknown or X on b while in_valid=1: the X propagates to p. No X-scrubbing is required. X on b while in_valid=0 has no effect on p.
- Reset mid-stream: all in-flight results are discarded. The first output after reset comes only from an input captured after rst_n rises.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold rst_n=0 with b=4'b1111 and in_valid=1 toggling -> p=00000 and out_valid=0 throughout. Assert rst_n=0 between clock edges -> outputs clear immediately, without waiting for an edge.
- Exhaustive sweep, LATENCY=1: in_valid=1 with b=0..15 on consecutive cycles -> after 1 cycle p follows the mapping table, e.g. b=9 -> 0_1001, b=10 -> 1_0000, b=15 -> 1_0101. out_valid stays high continuously.
- Exhaustive sweep, LATENCY=2: same stimulus -> identical sequence delayed one additional cycle. The first out_valid appears 2 edges after the first capture.
- Hold behaviour: b=13 with in_valid=1, then b=3 with in_valid=0 for 5 cycles -> p stays 1_0011 and out_valid=0 during the hold cycles.
- Boundary pair: b=9 then b=10 back-to-back -> p=0_1001 then 1_0000 on consecutive cycles. Also b=15 then b=0 -> 1_0101 then 0_0000.
- Reset mid-stream, LATENCY=2: feed b=12 and b=14, pulse rst_n low before both emerge -> neither 1_0010 nor 1_0100 is ever output. A post-reset input b=5 yields 0_0101 after 2 cycles.

Source files
------------

// File: rtl/bin_bcd4.sv
// Registered 4-bit binary to 2-digit packed BCD converter (tens in bit 4, ones in bits 3:0).
// One or two register stages between input capture and output, fully pipelined.
module bin_bcd4 #(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] b,
  output logic [4:0] p,
  output logic       out_valid
);

  logic [4:0] bcd;
  logic [4:0] src_p;
  logic       src_v;
  logic [4:0] p_d, p_q;
  logic       out_valid_d, out_valid_q;

  // NOTE: every branch assigns bcd, so no latch is inferred.
  always_comb begin
    if (b > 4'd9) bcd = {1'b1, b - 4'd10};
    else          bcd = {1'b0, b};
  end

  if (LATENCY == 1) begin : g_lat1
    assign src_p = bcd;
    assign src_v = in_valid;
  end else if (LATENCY == 2) begin : g_lat2
    logic [4:0] stg_p_d, stg_p_q;
    logic       stg_v_d, stg_v_q;

    // The stage holds its data when idle so X on b without in_valid never enters.
    always_comb begin
      stg_v_d = in_valid;
      stg_p_d = in_valid ? bcd : stg_p_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg_p_q <= 5'd0;
        stg_v_q <= 1'b0;
      end else begin
        stg_p_q <= stg_p_d;
        stg_v_q <= stg_v_d;
      end
    end

    assign src_p = stg_p_q;
    assign src_v = stg_v_q;
  end else begin : g_bad_latency
    $error("bin_bcd4: LATENCY must be 1 or 2");
  end

  always_comb begin
    out_valid_d = src_v;
    p_d         = src_v ? src_p : p_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= 5'd0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign p         = p_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bin_bcd4.sv
// Directed bench for bin_bcd4: runs LATENCY=1 and LATENCY=2 instances side by side
// on shared stimulus and checks {out_valid, p} against hand-computed values.
module tb_bin_bcd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] b = 4'd0;
  logic [4:0] p1, p2;
  logic       ov1, ov2;

  int n_assert = 0;
  int n_fail   = 0;

  // Hand-written BCD table for b = 0..15.
  logic [4:0] exp_tab [16] = '{
    5'b0_0000, 5'b0_0001, 5'b0_0010, 5'b0_0011,
    5'b0_0100, 5'b0_0101, 5'b0_0110, 5'b0_0111,
    5'b0_1000, 5'b0_1001, 5'b1_0000, 5'b1_0001,
    5'b1_0010, 5'b1_0011, 5'b1_0100, 5'b1_0101
  };

  bin_bcd4 #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .b(b), .p(p1), .out_valid(ov1)
  );

  bin_bcd4 #(.LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .b(b), .p(p2), .out_valid(ov2)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(input string tag, input logic [5:0] e1, input logic [5:0] e2);
    check({tag, "/L1"}, {ov1, p1}, e1);
    check({tag, "/L2"}, {ov2, p2}, e2);
  endtask

  initial begin
    // Asynchronous clear before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_both("async_reset_initial", 6'b0_00000, 6'b0_00000);

    // Held in reset with b=15 and in_valid toggling.
    b = 4'd15;
    for (int i = 0; i < 4; i++) begin
      in_valid = ~in_valid;
      tick();
      check_both($sformatf("reset_hold_%0d", i), 6'b0_00000, 6'b0_00000);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    check_both("post_release_idle", 6'b0_00000, 6'b0_00000);

    // Exhaustive sweep, back-to-back.
    for (int i = 0; i < 16; i++) begin
      b        = 4'(i);
      in_valid = 1'b1;
      tick();
      if (i == 0) check_both($sformatf("sweep_%0d", i), {1'b1, exp_tab[0]}, 6'b0_00000);
      else        check_both($sformatf("sweep_%0d", i), {1'b1, exp_tab[i]}, {1'b1, exp_tab[i-1]});
    end
    in_valid = 1'b0;
    tick();
    check_both("sweep_drain_1", 6'b0_10101, 6'b1_10101);
    tick();
    check_both("sweep_drain_2", 6'b0_10101, 6'b0_10101);

    // Hold: b=13 then idle with b=3.
    b        = 4'd13;
    in_valid = 1'b1;
    tick();
    check_both("hold_capture", 6'b1_10011, 6'b0_10101);
    b        = 4'd3;
    in_valid = 1'b0;
    tick();
    check_both("hold_0", 6'b0_10011, 6'b1_10011);
    for (int i = 1; i < 5; i++) begin
      tick();
      check_both($sformatf("hold_%0d", i), 6'b0_10011, 6'b0_10011);
    end

    // Boundary pairs 9->10 and 15->0.
    b = 4'd9;  in_valid = 1'b1; tick();
    check_both("bnd_9",  6'b1_01001, 6'b0_10011);
    b = 4'd10; tick();
    check_both("bnd_10", 6'b1_10000, 6'b1_01001);
    b = 4'd15; tick();
    check_both("bnd_15", 6'b1_10101, 6'b1_10000);
    b = 4'd0;  tick();
    check_both("bnd_0",  6'b1_00000, 6'b1_10101);
    in_valid = 1'b0; tick();
    check_both("bnd_drain_1", 6'b0_00000, 6'b1_00000);
    tick();
    check_both("bnd_drain_2", 6'b0_00000, 6'b0_00000);

    // Reset mid-stream: b=12 in flight, b=14 presented while reset is asserted.
    b = 4'd12; in_valid = 1'b1; tick();
    check_both("mid_cap_12", 6'b1_10010, 6'b0_00000);
    b     = 4'd14;
    rst_n = 1'b0;
    #1 check_both("mid_async_clear", 6'b0_00000, 6'b0_00000);
    tick();
    check_both("mid_in_reset", 6'b0_00000, 6'b0_00000);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_both($sformatf("mid_flushed_%0d", i), 6'b0_00000, 6'b0_00000);
    end
    b = 4'd5; in_valid = 1'b1; tick();
    check_both("post_reset_5_a", 6'b1_00101, 6'b0_00000);
    in_valid = 1'b0; b = 4'd7; tick();
    check_both("post_reset_5_b", 6'b0_00101, 6'b1_00101);
    tick();
    check_both("post_reset_5_c", 6'b0_00101, 6'b0_00101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
